// File: rtl/cfg_stream_sequencer.sv
// cfg_stream_sequencer: parses framed configuration records from a byte stream
// (tile id, addr hi, addr lo, count, payload) and issues one registered tile
// write per payload byte. A session opens on cfg_start and closes on EOS_ID.
// Build option: define CFG_STREAM_CHECKSUM_EN to require a trailing XOR
// checksum byte after each record's payload.
module cfg_stream_sequencer #(
  parameter int         NUM_TILES = 16,
  parameter logic [7:0] EOS_ID    = 8'hFF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_start,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  output logic [NUM_TILES-1:0] select_tile,
  output logic [9:0]           address_tile,
  output logic [7:0]           data_tile,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [8:0] NT = 9'(NUM_TILES);

`ifdef CFG_STREAM_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_TILE, S_ADDR_HI, S_ADDR_LO, S_COUNT, S_DATA, S_CHK, S_END
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_TILE, S_ADDR_HI, S_ADDR_LO, S_COUNT, S_DATA, S_END
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [7:0]           tile_q, tile_d;
  logic                 tile_ok_q, tile_ok_d;
  logic [9:0]           addr_q, addr_d;
  logic [8:0]           cnt_q, cnt_d;
  logic [NUM_TILES-1:0] sel_q, sel_d, onehot;
  logic [9:0]           addr_out_q, addr_out_d;
  logic [7:0]           data_out_q, data_out_d;
  logic                 err_q, err_d;
`ifdef CFG_STREAM_CHECKSUM_EN
  logic [7:0]           xor_q, xor_d;
`endif

  // Decode the latched tile id into its one-hot strobe pattern.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      if (tile_q == 8'(i)) onehot[i] = 1'b1;
    end
  end

  // Next-state, handshake and datapath updates for the record parser.
  always_comb begin
    state_d    = state_q;
    tile_d     = tile_q;
    tile_ok_d  = tile_ok_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    sel_d      = '0;
    addr_out_d = addr_out_q;
    data_out_d = data_out_q;
    err_d      = err_q;
`ifdef CFG_STREAM_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    s_ready    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d = S_TILE;
          err_d   = 1'b0;
        end
      end
      S_TILE: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          if (s_data == EOS_ID) begin
            state_d = S_END;
          end else begin
            tile_d    = s_data;
            tile_ok_d = ({1'b0, s_data} < NT);
            // Out-of-range tiles are still parsed; only their strobes are muted.
            if ({1'b0, s_data} >= NT) err_d = 1'b1;
`ifdef CFG_STREAM_CHECKSUM_EN
            xor_d = s_data;
`endif
            state_d = S_ADDR_HI;
          end
        end
      end
      S_ADDR_HI: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          addr_d  = {s_data[1:0], addr_q[7:0]};
`ifdef CFG_STREAM_CHECKSUM_EN
          xor_d   = xor_q ^ s_data;
`endif
          state_d = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          addr_d  = {addr_q[9:8], s_data};
`ifdef CFG_STREAM_CHECKSUM_EN
          xor_d   = xor_q ^ s_data;
`endif
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          // A zero count byte encodes a full 256-byte payload.
          cnt_d   = (s_data == 8'd0) ? 9'd256 : {1'b0, s_data};
`ifdef CFG_STREAM_CHECKSUM_EN
          xor_d   = xor_q ^ s_data;
`endif
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          if (tile_ok_q) begin
            sel_d      = onehot;
            addr_out_d = addr_q;
            data_out_d = s_data;
          end
          addr_d = addr_q + 10'd1;
          cnt_d  = cnt_q - 9'd1;
`ifdef CFG_STREAM_CHECKSUM_EN
          xor_d  = xor_q ^ s_data;
          if (cnt_q == 9'd1) state_d = S_CHK;
`else
          if (cnt_q == 9'd1) state_d = S_TILE;
`endif
        end
      end
`ifdef CFG_STREAM_CHECKSUM_EN
      S_CHK: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          if (s_data != xor_q) err_d = 1'b1;
          state_d = S_TILE;
        end
      end
`endif
      S_END: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Record fields, write outputs and sticky error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tile_q     <= '0;
      tile_ok_q  <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      sel_q      <= '0;
      addr_out_q <= '0;
      data_out_q <= '0;
      err_q      <= 1'b0;
`ifdef CFG_STREAM_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      tile_q     <= tile_d;
      tile_ok_q  <= tile_ok_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      addr_out_q <= addr_out_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
`ifdef CFG_STREAM_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign select_tile  = sel_q;
  assign address_tile = addr_out_q;
  assign data_tile    = data_out_q;
  assign err          = err_q;

endmodule

// File: tb/tb_cfg_stream_sequencer.sv
// Testbench for cfg_stream_sequencer: scoreboard of expected tile writes,
// pushed as payload bytes are accepted and popped by a write monitor.
module tb_cfg_stream_sequencer;
  localparam int NT = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_start = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_ready;
  logic [NT-1:0] select_tile;
  logic [9:0]    address_tile;
  logic [7:0]    data_tile;
  logic          busy, done, err;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int strobes = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [NT-1:0] sel;
    logic [9:0]    addr;
    logic [7:0]    data;
    int            cyc;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] pay_q[$];

  cfg_stream_sequencer #(.NUM_TILES(NT), .EOS_ID(8'hFF)) dut (
    .clock(clock), .reset(reset), .cfg_start(cfg_start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .select_tile(select_tile), .address_tile(address_tile), .data_tile(data_tile),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clock) begin
    if (mon_en && select_tile !== '0) begin
      strobes++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write sel=%h addr=%h data=%h required no write",
                 select_tile, address_tile, data_tile);
      end else begin
        mon_e = exp_q.pop_front();
        if (select_tile !== mon_e.sel || address_tile !== mon_e.addr ||
            data_tile !== mon_e.data || cyc != mon_e.cyc)
          $display("FAIL write got sel=%h addr=%h data=%h cyc=%0d required sel=%h addr=%h data=%h cyc=%0d",
                   select_tile, address_tile, data_tile, cyc,
                   mon_e.sel, mon_e.addr, mon_e.data, mon_e.cyc);
        else passed++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout cyc=%0d required finish", cyc);
    $fatal(1);
  end

  // Drive one byte (entered at a negedge); optionally expect a write from it.
  task automatic send_byte(input logic [7:0] b, input bit gap, input bit push,
                           input logic [NT-1:0] sel, input logic [9:0] addr);
    int  guard;
    wr_t w;
    guard   = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (s_ready !== 1'b1 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    checks++;
    if (guard >= 50) $display("FAIL ready_timeout byte=%h s_ready=%b required 1", b, s_ready);
    else passed++;
    if (push) begin
      w.sel = sel; w.addr = addr; w.data = b; w.cyc = cyc + 1;
      exp_q.push_back(w);
    end
    @(negedge clock);
    if (gap) begin
      s_valid = 1'b0;
      @(negedge clock);
    end
  endtask

  // Send header, payload from pay_q and (if built in) the checksum byte.
  task automatic send_record(input logic [7:0] tile, input logic [9:0] addr,
                             input logic [5:0] hi_junk, input bit rand_gap, input bit bad_chk);
    logic [7:0]    cnt_b, x, hi;
    logic [9:0]    a;
    logic [NT-1:0] oh;
    bit            ok;
    cnt_b = 8'(pay_q.size());
    hi    = {hi_junk, addr[9:8]};
    x     = tile ^ hi ^ addr[7:0] ^ cnt_b;
    ok    = ({1'b0, tile} < 9'(NT));
    oh    = ok ? (NT'(1) << tile) : '0;
    a     = addr;
    send_byte(tile, rand_gap && ($urandom_range(0, 1) == 1), 1'b0, '0, '0);
    send_byte(hi, rand_gap && ($urandom_range(0, 1) == 1), 1'b0, '0, '0);
    send_byte(addr[7:0], rand_gap && ($urandom_range(0, 1) == 1), 1'b0, '0, '0);
    send_byte(cnt_b, rand_gap && ($urandom_range(0, 1) == 1), 1'b0, '0, '0);
    foreach (pay_q[i]) begin
      x = x ^ pay_q[i];
      send_byte(pay_q[i], rand_gap && ($urandom_range(0, 1) == 1), ok, oh, a);
      a = a + 10'd1;
    end
`ifdef CFG_STREAM_CHECKSUM_EN
    send_byte(bad_chk ? (x ^ 8'h01) : x, 1'b0, 1'b0, '0, '0);
`else
    if (bad_chk) x = ~x;
`endif
  endtask

  task automatic start_session();
    cfg_start = 1'b1;
    @(negedge clock);
    cfg_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || err !== 1'b0 || s_ready !== 1'b1)
      $display("FAIL session_open busy=%b err=%b s_ready=%b required 1 0 1", busy, err, s_ready);
    else passed++;
  endtask

  task automatic end_session();
    send_byte(8'hFF, 1'b0, 1'b0, '0, '0);
    s_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0)
      $display("FAIL session_end done=%b busy=%b s_ready=%b required 1 0 0", done, busy, s_ready);
    else passed++;
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0)
      $display("FAIL idle_after_end done=%b busy=%b s_ready=%b required 0 0 0", done, busy, s_ready);
    else passed++;
  endtask

  task automatic drain();
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL missing_writes pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end else passed++;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if (select_tile !== '0 || address_tile !== '0 || data_tile !== '0 || s_ready !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_state sel=%h addr=%h data=%h rdy=%b busy=%b done=%b err=%b required all 0",
               select_tile, address_tile, data_tile, s_ready, busy, done, err);
    else passed++;
    reset = 1'b1;
    @(negedge clock);
    start_session();
    send_byte(8'h03, 0, 0, '0, '0);
    send_byte(8'h01, 0, 0, '0, '0);
    send_byte(8'h20, 0, 0, '0, '0);
    send_byte(8'h04, 0, 0, '0, '0);
    send_byte(8'hAA, 0, 0, '0, '0);
    send_byte(8'hBB, 0, 0, '0, '0);
    s_data = 8'hCC;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (select_tile !== '0 || address_tile !== '0 || data_tile !== '0 || s_ready !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
      $display("FAIL async_reset sel=%h addr=%h data=%h rdy=%b busy=%b done=%b err=%b required all 0",
               select_tile, address_tile, data_tile, s_ready, busy, done, err);
    else passed++;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (s_ready !== 1'b0 || busy !== 1'b0 || select_tile !== '0)
        $display("FAIL idle_after_reset s_ready=%b busy=%b sel=%h required 0 0 0", s_ready, busy, select_tile);
      else passed++;
    end
    s_valid = 1'b0;
    mon_en  = 1'b1;
  endtask

  task automatic test_basic_write();
    int s0;
    s0 = strobes;
    start_session();
    pay_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_record(8'h03, 10'h120, 6'h00, 1'b0, 1'b0);
    end_session();
    drain();
    checks++;
    if (strobes - s0 != 4 || err !== 1'b0)
      $display("FAIL basic_write strobes=%0d err=%b required 4 0", strobes - s0, err);
    else passed++;
  endtask

  task automatic test_back_to_back();
    start_session();
    pay_q = '{8'h11, 8'h22, 8'h33};
    send_record(8'h00, 10'h3FE, 6'h2A, 1'b0, 1'b0);
    pay_q = '{8'h44, 8'h55};
    send_record(8'h0F, 10'h000, 6'h3F, 1'b0, 1'b0);
    end_session();
    drain();
    checks++;
    if (err !== 1'b0) $display("FAIL wrap_err err=%b required 0", err);
    else passed++;
  endtask

  task automatic test_count_256();
    int s0;
    s0 = strobes;
    start_session();
    pay_q.delete();
    for (int i = 0; i < 256; i++) pay_q.push_back(8'($urandom));
    send_record(8'h05, 10'h2F0, 6'h00, 1'b1, 1'b0);
    end_session();
    drain();
    checks++;
    if (strobes - s0 != 256) $display("FAIL count_256 strobes=%0d required 256", strobes - s0);
    else passed++;
  endtask

  task automatic test_bad_tile();
    start_session();
    pay_q = '{8'h01, 8'h02};
    send_record(8'h20, 10'h010, 6'h00, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1) $display("FAIL bad_tile_err err=%b required 1", err);
    else passed++;
    pay_q = '{8'h77};
    send_record(8'h02, 10'h055, 6'h00, 1'b0, 1'b0);
    end_session();
    drain();
    checks++;
    if (err !== 1'b1) $display("FAIL err_sticky err=%b required 1", err);
    else passed++;
    start_session();
    end_session();
  endtask

`ifdef CFG_STREAM_CHECKSUM_EN
  task automatic test_checksum();
    start_session();
    pay_q = '{8'h5A};
    send_record(8'h01, 10'h010, 6'h00, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b0) $display("FAIL chk_good err=%b required 0", err);
    else passed++;
    send_record(8'h01, 10'h010, 6'h00, 1'b0, 1'b1);
    checks++;
    if (err !== 1'b1) $display("FAIL chk_bad err=%b required 1", err);
    else passed++;
    end_session();
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_write();
    test_back_to_back();
    test_count_256();
    test_bad_tile();
`ifdef CFG_STREAM_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cfg_stream_sequencer.md
Name: cfg_stream_sequencer

Overview:
- Converts a byte-wide configuration stream into tile configuration write cycles: one-hot `select_tile`, 10-bit `address_tile`, 8-bit `data_tile`.
- Sits between the fabric-level bitstream source and the per-tile loaders.
- Parses framed records (tile id, start address, byte count, payload) and issues one loader write per payload byte.
- A session is opened by `cfg_start` and closed by an end-of-session tile id.

Parameters:
- NUM_TILES, 16, number of tiles addressed; width of the `select_tile` vector; legal range 1..255.
- EOS_ID, 8'hFF, tile-id byte value that terminates a session.

Ports:
- clock  in  1  configuration clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_start  in  1  single-cycle pulse; opens a session when idle.
- s_valid  in  1  stream byte valid.
- s_ready  out  1  stream byte accepted when s_valid && s_ready.
- s_data  in  8  stream byte.
- select_tile  out  NUM_TILES  one-hot tile write strobe, one cycle per write.
- address_tile  out  10  write address inside the tile.
- data_tile  out  8  write data.
- busy  out  1  high while a session is open.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky error; cleared by the next cfg_start.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - select_tile, address_tile, data_tile, s_ready, busy, done, err all 0.
  - Internal counters cleared.
- States: IDLE, TILE, ADDR_HI, ADDR_LO, COUNT, DATA, CHK (CHK exists only with the optional feature), END.
- IDLE:
  - s_ready = 0.
  - cfg_start -> TILE, busy = 1, err cleared.
  - cfg_start is ignored in every other state.
- TILE:
  - Accepted byte == EOS_ID -> END.
  - Otherwise latch tile_id -> ADDR_HI.
  - tile_id >= NUM_TILES: set err; the record is still parsed and consumed, but no select bit is ever asserted for it.
- ADDR_HI: latch s_data[1:0] as addr[9:8]; s_data[7:2] ignored.
- ADDR_LO: latch addr[7:0].
- COUNT: latch count; value 0 means 256 bytes; -> DATA.
- DATA, per accepted byte:
  - Next cycle: select_tile = one-hot(tile_id), address_tile = addr, data_tile = byte.
  - Then addr = addr + 1, wrapping mod 1024 (0x3FF -> 0x000, no error).
  - remaining decrements; the last byte goes to TILE, or CHK if enabled.
- Write timing:
  - Outputs are registered; latency from byte acceptance to select strobe is exactly 1 cycle.
  - select_tile is all-zero in every cycle without a write.
  - address_tile and data_tile hold their last values between writes.
- Stream handshake:
  - s_ready = 1 in TILE, ADDR_HI, ADDR_LO, COUNT, DATA, CHK.
  - Back-to-back acceptance is allowed, so full throughput is 1 write per cycle.
  - s_valid low stalls the FSM with no side effects.
- END: done = 1 for one cycle, busy = 0, s_ready = 0; -> IDLE.
- Reset mid-record: immediate return to IDLE; any pending write strobe is dropped; partial writes already issued are not undone.
- Simultaneous last DATA byte and s_valid next cycle: the next byte is treated as a tile id without a bubble.

Optional Feature:
- Macro: CFG_STREAM_CHECKSUM_EN.
- Enabled:
  - After the last payload byte the FSM enters CHK and accepts one checksum byte.
  - The expected value is the XOR of tile id, addr_hi, addr_lo, count and all payload bytes.
  - A mismatch sets err. Writes are already issued and are not suppressed.
  - -> TILE.
- Disabled: CHK state and the XOR register are absent; the last DATA byte goes straight to TILE.

Test Plan:
1. Reset low mid-DATA with s_valid held high -> all outputs 0 asynchronously, state IDLE, s_ready 0; after release, s_ready stays 0 until cfg_start.
2. cfg_start; bytes 03, 01, 20, 04, AA, BB, CC, DD, FF with s_valid continuously high -> select_tile = 16'h0008 on 4 consecutive cycles, addresses 0x120..0x123, data AA..DD; done pulses once; err stays 0.
3. Record tile 00, addr 0x3FE, count 03 -> writes at 0x3FE, 0x3FF, 0x000; no err.
4. Count byte 00 followed by 256 payload bytes, with s_valid toggled randomly -> exactly 256 strobes, each exactly 1 cycle after its acceptance.
5. Tile id 0x20 with NUM_TILES = 16, count 02 -> err = 1, 2 payload bytes consumed, select_tile stays 0; the following valid record still writes normally.
6. With CFG_STREAM_CHECKSUM_EN: record 01, 00, 10, 01, 5A plus a checksum byte -> err stays 0 when checksum = 0x4A (01^00^10^01^5A); any other checksum value -> err = 1, write still issued.
